replay_buffer: RTL

Parametrised data-link-layer replay buffer. Stores every transmitted word with an auto-assigned sequence number until it is acknowledged. Purges entries on ACK and replays all unacknowledged entries in order on NAK or replay-timer expiry. Sits between the transaction-layer transmit path and the link transmitter; supersedes the fixed 16-bit `fifo`.

---
 rtl/replay_buffer_pkg.sv | 15 +
 rtl/replay_buffer_ram.sv | 24 ++
 rtl/replay_buffer.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/replay_buffer_pkg.sv
// Shared constants and types for the replay buffer.
package replay_buffer_pkg;

    localparam logic [1:0] ACKNAK_NONE = 2'b00;
    localparam logic [1:0] ACKNAK_ACK  = 2'b01;
    localparam logic [1:0] ACKNAK_NAK  = 2'b10;

    typedef enum logic {
        ST_IDLE,
        ST_REPLAY
    } state_e;

    localparam int unsigned REPLAY_NUM_W = 2;

endpackage

// File: rtl/replay_buffer_ram.sv
// Entry storage: one synchronous write port, one asynchronous read port.
module replay_buffer_ram #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 28
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/replay_buffer.sv
// Data-link replay buffer: sequence-numbered storage, ACK/NAK purge, in-order replay.
// Optional replay counter with retrain request is built when REPLAY_NUM_EN is defined.
module replay_buffer
    import replay_buffer_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned SEQ_W  = 12
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       wr,
    input  logic [DATA_W-1:0]          data_in,
    output logic [SEQ_W-1:0]           seq,
    input  logic [1:0]                 rd,
    input  logic [SEQ_W-1:0]           ack_seq,
    input  logic                       tim_out,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          data_out,
    output logic                       out_valid,
    output logic [SEQ_W-1:0]           out_seq,
    output logic                       rep,
    output logic [$clog2(DEPTH)-1:0]   replay_index,
    output logic [$clog2(DEPTH):0]     num_packets_to_replay,
    output logic                       empty,
    output logic                       full,
    output logic                       retrain
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    state_e            state_q, state_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  replay_ptr_q, replay_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [SEQ_W-1:0]  next_seq_q, next_seq_d;
    logic              pend_valid_q, pend_valid_d;
    logic [SEQ_W-1:0]  pend_seq_q, pend_seq_d;

    logic                    is_ack, is_nak, rep_active, full_w;
    logic                    wr_fire, handshake, last_hs, start;
    logic                    purge_req, purge_hit;
    logic [SEQ_W-1:0]        purge_seq, oldest_seq, purge_dist;
    logic [CNT_W-1:0]        purge_n, count_purged, count_next;
    logic [PTR_W-1:0]        rd_ptr_purged;
    logic [DATA_W+SEQ_W-1:0] rd_word;

    assign is_ack     = (rd == ACKNAK_ACK);
    assign is_nak     = (rd == ACKNAK_NAK);
    assign rep_active = (state_q == ST_REPLAY);
    assign full_w     = (count_q == CNT_W'(DEPTH));
    assign wr_fire    = en & wr & ~full_w & ~rep_active;
    assign handshake  = en & rep_active & out_ready;
    assign last_hs    = handshake & ((replay_ptr_q + PTR_W'(1)) == wr_ptr_q);

    // One purge datapath: live ACK/NAK while idle, or the deferred ACK as replay ends.
    always_comb begin
        purge_req = 1'b0;
        purge_seq = ack_seq;
        if (!rep_active) begin
            purge_req = en & (is_ack | is_nak);
        end else if (last_hs) begin
            purge_req = is_ack | pend_valid_q;
            purge_seq = is_ack ? ack_seq : pend_seq_q;
        end
    end

    assign oldest_seq    = next_seq_q - SEQ_W'(count_q);
    assign purge_dist    = purge_seq - oldest_seq;
    assign purge_hit     = purge_req & (purge_dist < SEQ_W'(count_q));
    assign purge_n       = purge_hit ? (CNT_W'(purge_dist) + CNT_W'(1)) : '0;
    assign count_purged  = count_q - purge_n;
    assign rd_ptr_purged = rd_ptr_q + PTR_W'(purge_n);
    assign count_next    = count_purged + CNT_W'(wr_fire);
    assign start         = en & ~rep_active & (is_nak | tim_out) & (count_next != '0);

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        replay_ptr_d = replay_ptr_q;
        next_seq_d   = next_seq_q;
        pend_valid_d = pend_valid_q;
        pend_seq_d   = pend_seq_q;
        rd_ptr_d     = rd_ptr_purged;
        count_d      = count_next;

        if (wr_fire) begin
            wr_ptr_d   = wr_ptr_q + PTR_W'(1);
            next_seq_d = next_seq_q + SEQ_W'(1);
        end

        if (start) begin
            state_d      = ST_REPLAY;
            replay_ptr_d = rd_ptr_purged;
        end

        if (en && rep_active) begin
            if (is_ack) begin
                pend_valid_d = 1'b1;
                pend_seq_d   = ack_seq;
            end
            if (handshake) begin
                replay_ptr_d = replay_ptr_q + PTR_W'(1);
            end
            if (last_hs) begin
                state_d      = ST_IDLE;
                pend_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            replay_ptr_q <= '0;
            count_q      <= '0;
            next_seq_q   <= '0;
            pend_valid_q <= 1'b0;
            pend_seq_q   <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            replay_ptr_q <= replay_ptr_d;
            count_q      <= count_d;
            next_seq_q   <= next_seq_d;
            pend_valid_q <= pend_valid_d;
            pend_seq_q   <= pend_seq_d;
        end
    end

    replay_buffer_ram #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_W + SEQ_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (wr_fire),
        .waddr_i (wr_ptr_q),
        .wdata_i ({next_seq_q, data_in}),
        .raddr_i (replay_ptr_q),
        .rdata_o (rd_word)
    );

    assign seq                   = next_seq_q;
    assign rep                   = rep_active;
    assign out_valid             = rep_active;
    assign data_out              = rep_active ? rd_word[DATA_W-1:0] : '0;
    assign out_seq               = rep_active ? rd_word[DATA_W+SEQ_W-1:DATA_W] : '0;
    assign replay_index          = replay_ptr_q;
    assign num_packets_to_replay = count_q;
    assign empty                 = (count_q == '0);
    assign full                  = full_w;

`ifdef REPLAY_NUM_EN
    logic [REPLAY_NUM_W-1:0] replay_num_q, replay_num_d;
    logic                    retrain_q, retrain_d;

    // A purging ACK/NAK clears the count before a same-cycle replay start counts.
    always_comb begin
        replay_num_d = replay_num_q;
        retrain_d    = 1'b0;
        if (purge_hit) begin
            replay_num_d = '0;
        end
        if (start) begin
            retrain_d    = (replay_num_d == '1);
            replay_num_d = replay_num_d + REPLAY_NUM_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            replay_num_q <= '0;
            retrain_q    <= 1'b0;
        end else begin
            replay_num_q <= replay_num_d;
            retrain_q    <= retrain_d;
        end
    end

    assign retrain = retrain_q;
`else
    assign retrain = 1'b0;
`endif

endmodule
